// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID-stage operand usage
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  // EX-stage status
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             ex_halt;
  // MEM-stage handshake with data memory
  logic             mem_req;
  logic             mem_ready;
  // Pipeline-register controls
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  // Status
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd, ex_redirect, ex_halt,
    output mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_flush, mem_wb_bubble,
    input  halted, mem_err, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd, ex_redirect, ex_halt,
    input  mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_flush, mem_wb_bubble,
    output halted, mem_err, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, EX
// redirects, data-memory wait/timeout, halt drain and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [1:0] DRAIN_N = 2'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       freeze;
  logic       load_use;
  logic       stall_event;
  logic [7:0] wcnt_inc;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  // A load in EX whose destination the ID instruction reads; x0 never hazards.
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign freeze   = hz.mem_req && !hz.mem_ready && (state_q != ST_HALTED);
  assign wcnt_inc = wcnt_q + 8'd1;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = 8'd0;
    dcnt_d        = dcnt_q;
    mem_err_d     = mem_err_q;
    stall_event   = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    if (!reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state_q == ST_HALTED) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; MEM/WB gets a bubble so WB never retires twice.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      stall_event   = 1'b1;
      wcnt_d        = wcnt_inc;
      if (wcnt_inc == TIMEOUT) begin
        mem_err_d = 1'b1;
        state_d   = ST_HALTED;
      end
    end else if (state_q == ST_DRAIN) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      dcnt_d      = dcnt_q - 2'd1;
      if (dcnt_q == 2'd1) begin
        state_d = ST_HALTED;
      end
    end else if (hz.ex_halt) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_DRAIN;
      dcnt_d      = DRAIN_N;
    end else if (hz.ex_redirect) begin
      // The ID instruction is discarded anyway, so a pending load-use is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall_event = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_event && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wcnt_q      <= 8'd0;
      dcnt_q      <= 2'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      dcnt_q      <= dcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.id_ex_write   = id_ex_write;
  assign hz.ex_mem_write  = ex_mem_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.halted        = (state_q == ST_HALTED);
  assign hz.mem_err       = mem_err_q;
  assign hz.stall_count   = stall_cnt_q;

  // A stopped pipeline must never advance, and a timeout always stops it.
  a_halted_frozen: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_HALTED) |-> (!pc_write && !if_id_write && !id_ex_write && !ex_mem_write));
  a_err_halts: assert property (@(posedge clk) disable iff (!reset)
    mem_err_q |-> (state_q == ST_HALTED));
  a_drain_cnt: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_DRAIN) |-> (dcnt_q != 2'd0));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations
// on the packed control word and the status outputs.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] C_NORMAL = 7'b1111_000;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_REDIR  = 7'b1111_110;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_DRAIN  = 7'b0111_110;
  localparam logic [6:0] C_HALTED = 7'b0000_111;
  localparam logic [6:0] C_RESET  = 7'b0000_111;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT  (16),
    .DRAIN_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  logic [6:0] ctrl;
  assign ctrl = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                 bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check combinational controls mid-cycle, then step past the next edge.
  task automatic cycle(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, {25'd0, ctrl}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.ex_halt     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = rd;
    bus.id_rs2      = rd;
    bus.id_use_rs2  = 1'b1;
  endtask

  task automatic check_status(input string tag, input logic h, input logic e, input int cnt);
    check({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, h});
    check({tag, "_mem_err"}, {31'd0, bus.mem_err}, {31'd0, e});
    check({tag, "_cnt"}, {16'd0, bus.stall_count}, 32'(cnt));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    clear_in();

    // Reset forcing and cleared state
    cycle("rst_ctrl", C_RESET);
    check_status("rst", 1'b0, 1'b0, 0);
    reset = 1'b1;
    cycle("post_rst", C_NORMAL);

    // Load-use through rs2: one bubble, counter 0 -> 1
    set_load_use(5'd5);
    cycle("lu_rs2", C_LU);
    check_status("lu_rs2", 1'b0, 1'b0, 1);
    clear_in();
    cycle("lu_clear", C_NORMAL);

    // x0 destination never stalls
    set_load_use(5'd0);
    cycle("lu_x0", C_NORMAL);
    check_status("lu_x0", 1'b0, 1'b0, 1);

    // rs1 match stalls; unused rs1 match does not
    clear_in();
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd7;
    bus.id_rs1      = 5'd7;
    bus.id_use_rs1  = 1'b1;
    cycle("lu_rs1", C_LU);
    bus.id_use_rs1  = 1'b0;
    cycle("lu_rs1_unused", C_NORMAL);
    check_status("lu_rs1", 1'b0, 1'b0, 2);

    // Redirect overrides load-use and is not counted
    clear_in();
    set_load_use(5'd5);
    bus.ex_redirect = 1'b1;
    cycle("redir_lu", C_REDIR);
    check_status("redir_lu", 1'b0, 1'b0, 2);

    // Three wait cycles (redirect during one is masked), then a normal advance
    clear_in();
    bus.mem_req = 1'b1;
    cycle("mwait_0", C_FREEZE);
    bus.ex_redirect = 1'b1;
    cycle("mwait_1", C_FREEZE);
    bus.ex_redirect = 1'b0;
    cycle("mwait_2", C_FREEZE);
    bus.mem_ready = 1'b1;
    cycle("mwait_done", C_NORMAL);
    check_status("mwait", 1'b0, 1'b0, 5);

    // One more load-use to bring the count to 6
    clear_in();
    set_load_use(5'd9);
    cycle("lu_again", C_LU);

    // Halt drain with a one-cycle freeze: halted at t+4
    clear_in();
    bus.ex_halt = 1'b1;
    cycle("halt_entry", C_DRAIN);
    check_status("halt_t1", 1'b0, 1'b0, 6);
    bus.ex_halt = 1'b0;
    bus.mem_req = 1'b1;
    cycle("drain_frz", C_FREEZE);
    bus.mem_req     = 1'b0;
    bus.ex_redirect = 1'b1;
    cycle("drain_1", C_DRAIN);
    check_status("halt_t3", 1'b0, 1'b0, 7);
    bus.ex_redirect = 1'b0;
    cycle("drain_2", C_DRAIN);
    check_status("halt_t4", 1'b1, 1'b0, 7);

    // HALTED ignores everything, counts nothing
    set_load_use(5'd5);
    bus.ex_redirect = 1'b1;
    bus.mem_req     = 1'b1;
    cycle("halted_0", C_HALTED);
    cycle("halted_1", C_HALTED);
    check_status("halted", 1'b1, 1'b0, 7);

    // Reset out of HALTED
    clear_in();
    reset = 1'b0;
    cycle("rst_halted", C_RESET);
    check_status("rst_halted", 1'b0, 1'b0, 0);
    reset = 1'b1;

    // Build count to 7 with freezes, then reset in the middle of a drain
    bus.mem_req = 1'b1;
    for (int i = 0; i < 7; i++) cycle("frz7", C_FREEZE);
    bus.mem_ready = 1'b1;
    cycle("frz7_done", C_NORMAL);
    clear_in();
    bus.ex_halt = 1'b1;
    cycle("halt2_entry", C_DRAIN);
    check_status("pre_rst", 1'b0, 1'b0, 7);
    bus.ex_halt = 1'b0;
    reset = 1'b0;
    cycle("rst_drain", C_RESET);
    check_status("rst_drain", 1'b0, 1'b0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle("post_rst_run", C_NORMAL);
    check_status("post_rst_run", 1'b0, 1'b0, 0);

    // Timeout: 16 frozen cycles, then sticky error/halt
    bus.mem_req = 1'b1;
    for (int i = 0; i < 15; i++) cycle("to_frz", C_FREEZE);
    check_status("to_pre", 1'b0, 1'b0, 15);
    cycle("to_last", C_FREEZE);
    check_status("to_hit", 1'b1, 1'b1, 16);
    bus.mem_req = 1'b0;
    cycle("to_sticky_0", C_HALTED);
    cycle("to_sticky_1", C_HALTED);
    check_status("to_sticky", 1'b1, 1'b1, 16);

    // Final reset clears the sticky error
    reset = 1'b0;
    cycle("rst_final", C_RESET);
    check_status("rst_final", 1'b0, 1'b0, 0);
    reset = 1'b1;
    cycle("final_run", C_NORMAL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
